// File: rtl/wb_reg_slave.sv
// Wishbone classic register-file responder.
// Fixed-latency single-access slave with err/rty terminations.
module wb_reg_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS     = 16,
  parameter int WAIT_STATES  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic                    we_i,
  input  logic [SELECT_WIDTH-1:0] sel_i,
  input  logic                    stb_i,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    rty_o,
  input  logic                    cyc_i,
  input  logic                    lock_i
);

  localparam int LSB = $clog2(SELECT_WIDTH);
  localparam int IW  = ADDR_WIDTH - LSB;
  localparam int RIW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  r_state;
  logic [7:0]              r_cnt;
  logic [IW-1:0]           r_idx;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic                    r_we;
  logic [SELECT_WIDTH-1:0] r_sel;
  logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0]   r_dat_o;
  logic                    r_ack;
  logic                    r_err;
  logic                    r_rty;

  logic                    w_idle;
  logic                    w_req;
  logic                    w_to_resp;
  logic [IW-1:0]           w_idx;
  logic [RIW-1:0]          w_ridx;
  logic [DATA_WIDTH-1:0]   w_wdat;
  logic                    w_we;
  logic [SELECT_WIDTH-1:0] w_sel;
  logic                    w_err;
  logic                    w_rty;
  logic                    w_ack;

  generate
    if (LSB > 0) begin : g_lsb
      logic w_unused;
      assign w_unused = ^adr_i[LSB-1:0];
    end
  endgenerate

  assign w_idle = (r_state == S_IDLE);
  assign w_req  = w_idle & cyc_i & stb_i;

  // Zero-wait accesses resolve straight from the bus inputs.
  assign w_to_resp = (w_req & (WAIT_STATES == 0))
                   | ((r_state == S_WAIT) & cyc_i & (r_cnt == 8'd1));

  assign w_idx  = w_idle ? adr_i[ADDR_WIDTH-1:LSB] : r_idx;
  assign w_wdat = w_idle ? dat_i : r_dat;
  assign w_we   = w_idle ? we_i  : r_we;
  assign w_sel  = w_idle ? sel_i : r_sel;
  assign w_ridx = w_idx[RIW-1:0];

  assign w_err = 32'(w_idx) >= 32'(NUM_REGS);
  assign w_rty = ~w_err & w_we & lock_i;
  assign w_ack = ~w_err & ~w_rty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dat   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_dat_o <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rty   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rty   <= 1'b0;
      r_dat_o <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_idx   <= adr_i[ADDR_WIDTH-1:LSB];
            r_dat   <= dat_i;
            r_we    <= we_i;
            r_sel   <= sel_i;
            r_cnt   <= 8'(WAIT_STATES);
            r_state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!cyc_i) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (r_cnt == 8'd1) begin
            r_cnt   <= '0;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      if (w_to_resp) begin
        r_ack <= w_ack;
        r_err <= w_err;
        r_rty <= w_rty;
        if (w_ack && w_we) begin
          for (int b = 0; b < SELECT_WIDTH; b++) begin
            if (w_sel[b]) begin
              r_regs[w_ridx][8*b +: 8] <= w_wdat[8*b +: 8];
            end
          end
        end
        if (w_ack && !w_we) begin
          r_dat_o <= r_regs[w_ridx];
        end
      end
    end
  end

  assign dat_o = r_dat_o;
  assign ack_o = r_ack;
  assign err_o = r_err;
  assign rty_o = r_rty;

endmodule

// File: tb/tb_wb_reg_slave.sv
// Directed scoreboard bench for wb_reg_slave.
// Three instances cover WAIT_STATES of 1, 3 and 0.
module tb_wb_reg_slave;

  typedef struct packed {
    logic [2:0]  rsp;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  adr = '0;
  logic [31:0] dat = '0;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        lock = 1'b0;
  int          cur = 1;

  logic [31:0] dat0, dat1, dat3;
  logic        ack0, ack1, ack3;
  logic        err0, err1, err3;
  logic        rty0, rty1, rty3;
  logic        cyc0, cyc1, cyc3;

  logic [2:0]  o_rsp;
  logic [31:0] o_dat;

  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  logic [31:0] mem [4][16];

  always #5 clk = ~clk;

  assign cyc0 = cyc & (cur == 0);
  assign cyc1 = cyc & (cur == 1);
  assign cyc3 = cyc & (cur == 3);

  always_comb begin
    o_rsp = {ack1, err1, rty1};
    o_dat = dat1;
    if (cur == 0) begin
      o_rsp = {ack0, err0, rty0};
      o_dat = dat0;
    end else if (cur == 3) begin
      o_rsp = {ack3, err3, rty3};
      o_dat = dat3;
    end
  end

  wb_reg_slave #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n), .adr_i(adr), .dat_i(dat), .dat_o(dat1),
    .we_i(we), .sel_i(sel), .stb_i(stb), .ack_o(ack1), .err_o(err1),
    .rty_o(rty1), .cyc_i(cyc1), .lock_i(lock)
  );

  wb_reg_slave #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .adr_i(adr), .dat_i(dat), .dat_o(dat3),
    .we_i(we), .sel_i(sel), .stb_i(stb), .ack_o(ack3), .err_o(err3),
    .rty_o(rty3), .cyc_i(cyc3), .lock_i(lock)
  );

  wb_reg_slave #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .adr_i(adr), .dat_i(dat), .dat_o(dat0),
    .we_i(we), .sel_i(sel), .stb_i(stb), .ack_o(ack0), .err_o(err0),
    .rty_o(rty0), .cyc_i(cyc0), .lock_i(lock)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 16; i++)
        mem[k][i] = '0;
  endtask

  function automatic exp_t predict(input int k, input bit w,
                                   input logic [7:0] a, input logic [31:0] d,
                                   input logic [3:0] s, input bit lk);
    exp_t e;
    int   idx;
    idx = int'(a >> 2);
    e.dat = '0;
    if (idx >= 16) begin
      e.rsp = 3'b010;
    end else if (w && lk) begin
      e.rsp = 3'b001;
    end else begin
      e.rsp = 3'b100;
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mem[k][idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        e.dat = mem[k][idx];
      end
    end
    return e;
  endfunction

  task automatic access(input string tag, input int k, input int ws,
                        input bit w, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input bit lk);
    exp_t e;
    int   lat;
    bit   got;
    sb.push_back(predict(k, w, a, d, s, lk));
    @(posedge clk);
    #1;
    cur = k; we = w; adr = a; dat = d; sel = s; lock = lk;
    cyc = 1'b1; stb = 1'b1;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < ws + 6; i++) begin
      @(negedge clk);
      if (o_rsp != 3'b000) begin
        lat = i;
        got = 1'b1;
        break;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      chk({tag, "_timeout"}, 64'(o_rsp), 64'(e.rsp));
    end else begin
      chk({tag, "_lat"}, 64'(lat), 64'(ws + 1));
      chk({tag, "_rsp"}, 64'(o_rsp), 64'(e.rsp));
      chk({tag, "_dat"}, 64'(o_dat), 64'(e.dat));
    end
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; lock = 1'b0;
    @(negedge clk);
    chk({tag, "_after"}, {29'd0, o_rsp, o_dat}, 64'd0);
  endtask

  initial begin
    exp_t e;
    clear_model();
    repeat (3) @(negedge clk);
    chk("reset_ws1", {29'd0, ack1, err1, rty1, dat1}, 64'd0);
    chk("reset_ws0", {29'd0, ack0, err0, rty0, dat0}, 64'd0);
    rst_n = 1'b1;

    access("wr04", 1, 1, 1, 8'h04, 32'hDEADBEEF, 4'hF, 0);
    access("rd04", 1, 1, 0, 8'h04, 32'h0, 4'hF, 0);
    access("rd06", 1, 1, 0, 8'h06, 32'h0, 4'h1, 0);
    access("wr08a", 1, 1, 1, 8'h08, 32'h11223344, 4'hF, 0);
    access("wr08b", 1, 1, 1, 8'h08, 32'hAABBCCDD, 4'h5, 0);
    access("rd08", 1, 1, 0, 8'h08, 32'h0, 4'hF, 0);
    chk("model08", 64'(mem[1][2]), 64'h11BB33DD);
    access("rd40", 1, 1, 0, 8'h40, 32'h0, 4'hF, 0);
    access("wr40", 1, 1, 1, 8'h40, 32'hCAFEF00D, 4'hF, 0);
    access("wr40lk", 1, 1, 1, 8'h40, 32'hCAFEF00D, 4'hF, 1);
    access("rd00", 1, 1, 0, 8'h00, 32'h0, 4'hF, 0);
    access("wr0Clk", 1, 1, 1, 8'h0C, 32'h5, 4'hF, 1);
    access("rd0Clk", 1, 1, 0, 8'h0C, 32'h0, 4'hF, 1);
    access("rd04lk", 1, 1, 0, 8'h04, 32'h0, 4'hF, 1);

    access("wr10_ws3", 3, 3, 1, 8'h10, 32'h0BADF00D, 4'hF, 0);
    access("rd10_ws3", 3, 3, 0, 8'h10, 32'h0, 4'hF, 0);

    @(posedge clk);
    #1;
    cur = 3; we = 1'b1; adr = 8'h14; dat = 32'h12345678; sel = 4'hF;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #1;
    stb = 1'b0;
    @(posedge clk);
    #1;
    cyc = 1'b0; we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_quiet", 64'(o_rsp), 64'd0);
    end
    access("rd14_ws3", 3, 3, 0, 8'h14, 32'h0, 4'hF, 0);

    @(posedge clk);
    #1;
    cur = 3; we = 1'b1; adr = 8'h18; dat = 32'h87654321; sel = 4'hF;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wait", {29'd0, o_rsp, o_dat}, 64'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_quiet", 64'(o_rsp), 64'd0);
    end
    access("rd18_ws3", 3, 3, 0, 8'h18, 32'h0, 4'hF, 0);
    access("rd10_clr", 3, 3, 0, 8'h10, 32'h0, 4'hF, 0);
    access("rd04_clr", 1, 1, 0, 8'h04, 32'h0, 4'hF, 0);

    access("wr00_ws0", 0, 0, 1, 8'h00, 32'hA0A0A0A0, 4'hF, 0);
    access("wr04_ws0", 0, 0, 1, 8'h04, 32'hB1B1B1B1, 4'hF, 0);
    access("wr08_ws0", 0, 0, 1, 8'h08, 32'hC2C2C2C2, 4'hF, 0);

    sb.push_back(predict(0, 0, 8'h00, 32'h0, 4'hF, 0));
    sb.push_back(predict(0, 0, 8'h04, 32'h0, 4'hF, 0));
    sb.push_back(predict(0, 0, 8'h08, 32'h0, 4'hF, 0));
    @(posedge clk);
    #1;
    cur = 0; we = 1'b0; adr = 8'h00; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #1;
    adr = 8'h04;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("b2b_ack", 64'(o_rsp), (c % 2 == 0 && c < 5) ? 64'h4 : 64'h0);
      if (o_rsp[2]) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("b2b_dat", 64'(o_dat), 64'(e.dat));
        end else begin
          chk("b2b_extra", 64'(o_rsp), 64'd0);
        end
      end
      @(posedge clk);
      #1;
      if (c == 1) adr = 8'h08;
      if (c == 3) begin
        cyc = 1'b0; stb = 1'b0;
      end
    end
    chk("b2b_drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
